// File: rtl/hvsync_gen.sv
// Video timing generator: free-running h/v counters, registered sync/de/coordinate
// outputs with one cycle of latency, and a small test-pattern colour source.
module hvsync_gen #(
  parameter int   H_SYNC  = 144,
  parameter int   H_BACK  = 248,
  parameter int   H_ACT   = 1280,
  parameter int   H_FRONT = 16,
  parameter int   V_SYNC  = 3,
  parameter int   V_BACK  = 38,
  parameter int   V_ACT   = 1024,
  parameter int   V_FRONT = 1,
  parameter logic H_POL   = 1'b1,
  parameter logic V_POL   = 1'b1,
  parameter int   CW      = 12,
  parameter int   CDW     = 4
) (
  input  logic             pixel_clock,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic [3*CDW-1:0] solid_rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CW-1:0]    x,
  output logic [CW-1:0]    y,
  output logic             frame_start,
  output logic [CDW-1:0]   r,
  output logic [CDW-1:0]   g,
  output logic [CDW-1:0]   b
);

  localparam int H_TOTAL   = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOTAL   = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam int H_A_START = H_SYNC + H_BACK;
  localparam int V_A_START = V_SYNC + V_BACK;

  typedef enum logic [1:0] {
    MODE_BLACK = 2'd0,
    MODE_XOR   = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  logic [CW-1:0]  hcount_q, hcount_d;
  logic [CW-1:0]  vcount_q, vcount_d;
  mode_e          mode_q, mode_d, mode_eff;
  logic           hsync_q, hsync_d, vsync_q, vsync_d;
  logic           de_q, de_d, fs_q, fs_d;
  logic [CW-1:0]  x_q, x_d, y_q, y_d;
  logic [CDW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  int            h, v, x_int, y_int;
  logic          at_origin;
  logic [CW-1:0] xor_v;
  logic [2:0]    bar_k;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    h         = int'(hcount_q);
    v         = int'(vcount_q);
    x_int     = h - H_A_START;
    y_int     = v - V_A_START;
    at_origin = (hcount_q == '0) && (vcount_q == '0);

    hcount_d = (h == H_TOTAL - 1) ? '0 : hcount_q + CW'(1);
    vcount_d = vcount_q;
    if (h == H_TOTAL - 1) vcount_d = (v == V_TOTAL - 1) ? '0 : vcount_q + CW'(1);

    // Mode is captured only at the frame origin so a pattern never changes mid-frame.
    mode_d   = at_origin ? mode_e'(mode) : mode_q;
    mode_eff = mode_d;

    hsync_d = (h < H_SYNC) ? H_POL : ~H_POL;
    vsync_d = (v < V_SYNC) ? V_POL : ~V_POL;
    de_d    = (h >= H_A_START) && (h < H_A_START + H_ACT) &&
              (v >= V_A_START) && (v < V_A_START + V_ACT);
    fs_d    = at_origin;
    x_d     = de_d ? CW'(x_int) : x_q;
    y_d     = de_d ? CW'(y_int) : y_q;

    xor_v = CW'(x_int) ^ CW'(y_int);

    // Bar index floor(x*8/H_ACT) as a count of constant thresholds crossed; no divider.
    bar_k = '0;
    for (int i = 1; i < 8; i++)
      if (x_int * 8 >= i * H_ACT) bar_k = bar_k + 3'd1;

    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (de_d) begin
      unique case (mode_eff)
        MODE_XOR: begin
          r_d = CDW'(xor_v >> 6);
          g_d = CDW'(xor_v >> 4);
          b_d = CDW'(xor_v >> 2);
        end
        MODE_BARS: begin
          r_d = {CDW{bar_k[2]}};
          g_d = {CDW{bar_k[1]}};
          b_d = {CDW{bar_k[0]}};
        end
        MODE_SOLID: {r_d, g_d, b_d} = solid_rgb;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments and every one, including the latched mode, is reset.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
      mode_q   <= MODE_BLACK;
      hsync_q  <= ~H_POL;
      vsync_q  <= ~V_POL;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      mode_q   <= mode_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      fs_q     <= fs_d;
      x_q      <= x_d;
      y_q      <= y_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;

endmodule

// File: tb/tb_hvsync_gen.sv
// Scoreboard bench for hvsync_gen on a small timing set; a second instance with
// inverted sync polarity shares all stimulus.
module tb_hvsync_gen;

  localparam int HS = 2, HB = 3, HA = 8, HF = 1;
  localparam int VS = 1, VB = 1, VA = 4, VF = 1;
  localparam int HT = HS + HB + HA + HF;   // 14
  localparam int VT = VS + VB + VA + VF;   // 7
  localparam int FRAME = HT * VT;          // 98

  logic        clk;
  logic        reset_n;
  logic [1:0]  mode;
  logic [11:0] solid_rgb;

  logic       hsync, vsync, de, fs;
  logic [7:0] x, y;
  logic [3:0] r, g, b;

  logic       hsync_n, vsync_n, de_n, fs_n;
  logic [7:0] x_n, y_n;
  logic [3:0] r_n, g_n, b_n;

  hvsync_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACT(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACT(VA), .V_FRONT(VF),
    .H_POL(1'b1), .V_POL(1'b1), .CW(8), .CDW(4)
  ) dut (
    .pixel_clock(clk), .reset_n(reset_n), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(fs), .r(r), .g(g), .b(b)
  );

  hvsync_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACT(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACT(VA), .V_FRONT(VF),
    .H_POL(1'b0), .V_POL(1'b0), .CW(8), .CDW(4)
  ) dut_n (
    .pixel_clock(clk), .reset_n(reset_n), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(hsync_n), .vsync(vsync_n), .de(de_n), .x(x_n), .y(y_n),
    .frame_start(fs_n), .r(r_n), .g(g_n), .b(b_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       hs, vs, de, fs;
    logic [7:0] x, y;
    logic [3:0] r, g, b;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: counters the DUT will see at the next rising edge.
  int m_h, m_v, m_x, m_y;
  logic [1:0] m_mode;

  int st_fs, st_de, st_hs, st_vs;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_x = 0; m_y = 0; m_mode = 2'd0;
    sb.delete();
  endtask

  task automatic stats_clear();
    st_fs = 0; st_de = 0; st_hs = 0; st_vs = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hsync"},   int'(hsync),   0);
    check({tag, "_vsync"},   int'(vsync),   0);
    check({tag, "_hsync_n"}, int'(hsync_n), 1);
    check({tag, "_vsync_n"}, int'(vsync_n), 1);
    check({tag, "_de"},      int'(de),      0);
    check({tag, "_fs"},      int'(fs),      0);
    check({tag, "_xy"},      int'({x, y}),  0);
    check({tag, "_rgb"},     int'({r, g, b}), 0);
  endtask

  // Predict one output cycle, let one edge pass, then compare on the falling edge.
  task automatic cycle();
    exp_t e;
    logic [1:0] em;
    logic [7:0] xv;
    int k;
    em = (m_h == 0 && m_v == 0) ? mode : m_mode;
    if (m_h == 0 && m_v == 0) m_mode = mode;
    e.hs = (m_h < HS);
    e.vs = (m_v < VS);
    e.de = (m_h >= HS + HB) && (m_h < HS + HB + HA) && (m_v >= VS + VB) && (m_v < VS + VB + VA);
    e.fs = (m_h == 0 && m_v == 0);
    if (e.de) begin
      m_x = m_h - (HS + HB);
      m_y = m_v - (VS + VB);
    end
    e.x = 8'(m_x);
    e.y = 8'(m_y);
    e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
    if (e.de) begin
      case (em)
        2'd1: begin
          xv  = 8'(m_x) ^ 8'(m_y);
          e.r = {2'b00, xv[7:6]};
          e.g = xv[7:4];
          e.b = xv[5:2];
        end
        2'd2: begin
          k   = (m_x * 8) / HA;
          e.r = k[2] ? 4'hF : 4'h0;
          e.g = k[1] ? 4'hF : 4'h0;
          e.b = k[0] ? 4'hF : 4'h0;
        end
        2'd3: {e.r, e.g, e.b} = solid_rgb;
        default: ;
      endcase
    end
    sb.push_back(e);
    if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end

    @(negedge clk);
    e = sb.pop_front();
    check("hsync",   int'(hsync),   int'(e.hs));
    check("vsync",   int'(vsync),   int'(e.vs));
    check("hsync_n", int'(hsync_n), int'(!e.hs));
    check("vsync_n", int'(vsync_n), int'(!e.vs));
    check("de",      int'(de),      int'(e.de));
    check("fs",      int'(fs),      int'(e.fs));
    check("x",       int'(x),       int'(e.x));
    check("y",       int'(y),       int'(e.y));
    check("r",       int'(r),       int'(e.r));
    check("g",       int'(g),       int'(e.g));
    check("b",       int'(b),       int'(e.b));
    st_fs += int'(fs);
    st_de += int'(de);
    st_hs += int'(hsync);
    st_vs += int'(vsync);
  endtask

  initial begin
    reset_n   = 1'b0;
    mode      = 2'd0;
    solid_rgb = 12'h000;
    model_reset();
    stats_clear();
    repeat (2) @(negedge clk);
    check_reset("rst");

    // Two black frames: timing, de window and coordinates.
    reset_n = 1'b1;
    repeat (2 * FRAME) cycle();
    check("fs_count",  st_fs, 2);
    check("de_count",  st_de, 2 * HA * VA);
    check("hs_count",  st_hs, 2 * HS * VT);
    check("vs_count",  st_vs, 2 * VS * HT);

    // Solid colour, requested mid-frame; takes effect at the next frame.
    repeat (30) cycle();
    mode      = 2'd3;
    solid_rgb = 12'hA5C;
    repeat (2 * FRAME) cycle();

    // XOR frame, then switch to bars mid-frame.
    mode = 2'd1;
    repeat (FRAME + 40) cycle();
    mode = 2'd2;
    repeat (2 * FRAME) cycle();

    // Random solid colours sampled every cycle.
    mode = 2'd3;
    for (int i = 0; i < FRAME; i++) begin
      solid_rgb = 12'($urandom_range(0, 4095));
      cycle();
    end

    // Asynchronous reset in the middle of a line.
    for (int n = 0; n < 2 * FRAME && !(m_h == 5 && m_v == 3); n++) cycle();
    reset_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (3) @(negedge clk);
    check_reset("midrst_hold");
    reset_n = 1'b1;
    model_reset();
    stats_clear();
    mode = 2'd2;
    repeat (FRAME) cycle();
    check("fs_after_rst", st_fs, 1);
    check("de_after_rst", st_de, HA * VA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
